avst_packet_arbiter: RTL and testbench
======================================

# avst_packet_arbiter

Packet-level round-robin arbiter merging `num_inputs` Avalon-ST sources onto one Avalon-ST stream that feeds `avst_fifo`. A grant is taken on a start-of-packet (SOP) beat and held until the matching end-of-packet (EOP) beat, so packets never interleave. The source index is stamped onto the output channel. One registered output stage gives a fixed one-cycle latency.

## Interface
Parameters:
- `num_inputs`, 4, number of sources, 2..2**`channel_width`
- `channel_width`, 4, output channel width
- `data_width`, 32, data width per beat
- `empty_width`, 2, empty field width

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: clock
- `reset_n` input 1: asynchronous active-low reset
- `avst_sop_i` input `num_inputs`: SOP per source
- `avst_eop_i` input `num_inputs`: EOP per source
- `avst_empty_i` input `num_inputs*empty_width`: empty per source, source k at bits [k*empty_width +: empty_width]
- `avst_data_i` input `num_inputs*data_width`: data per source, same packing as empty
- `avst_valid_i` input `num_inputs`: valid per source
- `avst_ready_o` output `num_inputs`: ready per source
- `avst_channel_o` output `channel_width`: index of the granted source, zero-extended
- `avst_sop_o`, `avst_eop_o` output 1 each: SOP and EOP of the output beat
- `avst_empty_o` output `empty_width`: empty of the output beat
- `avst_data_o` output `data_width`: data of the output beat
- `avst_valid_o` output 1: output beat valid
- `avst_ready_i` input 1: downstream ready
- `err_orphan_o` output 1: one-cycle pulse when an orphan beat is discarded

## Operation
- States: IDLE, LOCKED. The block also holds `grant` (source index) and `ptr` (highest-priority index).
- `load` = !`avst_valid_o` || `avst_ready_i`. The output register accepts a beat only when `load` is 1.
- **IDLE:**
  - Requesters are sources with valid & sop.
  - Round-robin pick: the first requester found from `ptr` upward, wrapping modulo `num_inputs`.
  - The picked source gets ready = `load`; all other requesters get ready = 0.
  - If the beat is accepted and has no EOP: go to LOCKED and set `grant` = pick.
  - If the beat is accepted and has EOP (single-beat packet): stay in IDLE and set `ptr` = pick+1 mod `num_inputs`.
- **LOCKED:**
  - Only `grant` has ready = `load`; every other source has ready = 0, including sources with SOP.
  - When an EOP beat from `grant` is accepted: go to IDLE and set `ptr` = `grant`+1 mod `num_inputs`.
  - A beat from `grant` with SOP while LOCKED is forwarded unchanged. No protocol repair is done.
- **Orphans in IDLE:**
  - An orphan is a beat with valid & !sop from any source.
  - Orphans are discarded: that source gets ready = 1 whatever the value of `load`.
  - `err_orphan_o` pulses on the next cycle if at least one orphan was discarded.
  - Orphan discard may happen in the same cycle as a grant to a different source.
- **Output register update** on an accepted beat:
  - loads sop, eop, empty, data and channel = source index, and sets valid = 1.
  - If `avst_ready_i` is 1 and nothing is accepted, valid clears.
- All ready outputs are combinational from state, `avst_valid_i`, `avst_sop_i`, `avst_valid_o` and `avst_ready_i`. They do not depend on `avst_ready_i` when `avst_valid_o` is 0.
- `avst_empty_i` is passed through untouched. Its meaning is checked only by the consumer.

## Timing
- Reset state:
  - all outputs 0 (`avst_ready_o` is 0 because state is IDLE with no requesters)
  - state IDLE, `ptr` = 0, `grant` = 0
- Latency: an input beat accepted in cycle n appears on the output in cycle n+1.
- Throughput: one beat per cycle when downstream is always ready.
- Back-to-back packets from different sources have zero bubble: EOP accepted in cycle n, next SOP accepted in cycle n+1.
- Back-pressure: when `avst_ready_i` = 0 with `avst_valid_o` = 1, the output holds stable and all sources see ready = 0, except orphan discards in IDLE.
- Reset asserted mid-packet clears the output immediately (asynchronous). After release the state is IDLE, so the rest of the interrupted packet is discarded as orphans.
- Simultaneous SOPs on all sources are served in order `ptr`, `ptr`+1, ... with no starvation.

## Structure
- Package `avst_arb_pkg`:
  - state enum `arb_state_t` (IDLE, LOCKED)
  - default-parameter localparams
  - function `next_idx(idx, n)`, the wrap-around increment
- Sub-module `rr_pick`, parameter `num_inputs`:
  - inputs: `req` vector and `ptr`
  - outputs: `found` flag and `idx`
  - purely combinational priority rotate
- Top level holds the FSM, the ready generation and the output register.

## Test plan
- Single source, 1000 packets of random length 5..30, downstream always ready -> output beats match input beats exactly, channel = 0, one-cycle latency.
- All 4 sources assert SOP in cycle 0, each with a 3-beat packet -> output channel sequence 0,0,0,1,1,1,2,2,2,3,3,3 with no bubble; `ptr` = 0 afterwards.
- Source 2 is LOCKED mid-packet while source 1 asserts SOP -> source 1 ready stays 0 until source 2's EOP is accepted; source 1's SOP appears on the output on the next cycle.
- Random `avst_ready_i` at 50% during a 20-beat packet -> no beat lost or duplicated, and the output is stable while stalled.
- Orphan beat (valid, no SOP) on source 3 in IDLE -> source 3 ready = 1, nothing is output, and `err_orphan_o` pulses exactly once.
- `reset_n` pulsed low at beat 7 of 12 -> outputs go to 0 immediately; after release, beats 8..12 are discarded as orphans (5 pulses on `err_orphan_o`).

Source files
------------

// File: rtl/avst_arb_pkg.sv
// Shared types and helpers for the Avalon-ST packet arbiter.
package avst_arb_pkg;

  localparam int unsigned NUM_INPUTS_DEF    = 4;
  localparam int unsigned CHANNEL_WIDTH_DEF = 4;
  localparam int unsigned DATA_WIDTH_DEF    = 32;
  localparam int unsigned EMPTY_WIDTH_DEF   = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Increment an index, wrapping to 0 at n.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of req_i at or above ptr_i, wrapping.
module rr_pick #(
  parameter  int unsigned num_inputs = 4,
  localparam int unsigned IW         = $clog2(num_inputs)
) (
  input  logic [num_inputs-1:0] req_i,
  input  logic [IW-1:0]         ptr_i,
  output logic                  found_o,
  output logic [IW-1:0]         idx_o
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    found_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 0; off < num_inputs; off++) begin
      cand = 32'(ptr_i) + off;
      if (cand >= num_inputs) cand = cand - num_inputs;
      cand_idx = IW'(cand);
      if (!found_o && req_i[cand_idx]) begin
        found_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/avst_packet_arbiter.sv
// Packet-level round-robin Avalon-ST arbiter with a single registered output stage.
module avst_packet_arbiter
  import avst_arb_pkg::*;
#(
  parameter  int unsigned num_inputs    = NUM_INPUTS_DEF,
  parameter  int unsigned channel_width = CHANNEL_WIDTH_DEF,
  parameter  int unsigned data_width    = DATA_WIDTH_DEF,
  parameter  int unsigned empty_width   = EMPTY_WIDTH_DEF,
  localparam int unsigned IW            = $clog2(num_inputs)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [num_inputs-1:0]             avst_sop_i,
  input  logic [num_inputs-1:0]             avst_eop_i,
  input  logic [num_inputs*empty_width-1:0] avst_empty_i,
  input  logic [num_inputs*data_width-1:0]  avst_data_i,
  input  logic [num_inputs-1:0]             avst_valid_i,
  output logic [num_inputs-1:0]             avst_ready_o,
  output logic [channel_width-1:0]          avst_channel_o,
  output logic                              avst_sop_o,
  output logic                              avst_eop_o,
  output logic [empty_width-1:0]            avst_empty_o,
  output logic [data_width-1:0]             avst_data_o,
  output logic                              avst_valid_o,
  input  logic                              avst_ready_i,
  output logic                              err_orphan_o,
  output arb_state_t                        dbg_state_o,
  output logic [IW-1:0]                     dbg_ptr_o
);

  // Handshake: a source beat transfers on a cycle where its valid and ready are both 1;
  // the output beat transfers when avst_valid_o and avst_ready_i are both 1.

  arb_state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [num_inputs-1:0] req, orphan;
  logic                  pick_found;
  logic [IW-1:0]         pick_idx;
  logic                  load;

  logic [IW-1:0]          sel_idx;
  logic                   sel_valid, accept;
  logic                   sel_sop, sel_eop;
  logic [empty_width-1:0] sel_empty;
  logic [data_width-1:0]  sel_data;
  logic                   err_d;

  logic                     valid_q, sop_q, eop_q, err_q;
  logic [empty_width-1:0]   empty_q;
  logic [data_width-1:0]    data_q;
  logic [channel_width-1:0] chan_q;

  assign req    = avst_valid_i & avst_sop_i;
  assign orphan = avst_valid_i & ~avst_sop_i;
  assign load   = !valid_q || avst_ready_i;

  rr_pick #(.num_inputs(num_inputs)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    sel_idx   = (state_q == LOCKED) ? grant_q : pick_idx;
    sel_valid = (state_q == LOCKED) ? avst_valid_i[grant_q] : pick_found;
    accept    = sel_valid && load;
    sel_sop   = avst_sop_i[sel_idx];
    sel_eop   = avst_eop_i[sel_idx];
    sel_empty = avst_empty_i[32'(sel_idx) * empty_width +: empty_width];
    sel_data  = avst_data_i[32'(sel_idx) * data_width +: data_width];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel_eop) begin
            ptr_d = IW'(next_idx(32'(pick_idx), num_inputs));
          end else begin
            state_d = LOCKED;
            grant_d = pick_idx;
          end
        end
      end
      LOCKED: begin
        if (accept && sel_eop) begin
          state_d = IDLE;
          ptr_d   = IW'(next_idx(32'(grant_q), num_inputs));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Orphans are drained in IDLE regardless of downstream back-pressure.
  always_comb begin
    avst_ready_o = '0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) avst_ready_o[pick_idx] = load;
        avst_ready_o = avst_ready_o | orphan;
        err_d        = |orphan;
      end
      LOCKED: avst_ready_o[grant_q] = load;
      default: avst_ready_o = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_d;
      if (accept) begin
        valid_q <= 1'b1;
        sop_q   <= sel_sop;
        eop_q   <= sel_eop;
        empty_q <= sel_empty;
        data_q  <= sel_data;
        chan_q  <= channel_width'(sel_idx);
      end else if (avst_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign avst_valid_o   = valid_q;
  assign avst_sop_o     = sop_q;
  assign avst_eop_o     = eop_q;
  assign avst_empty_o   = empty_q;
  assign avst_data_o    = data_q;
  assign avst_channel_o = chan_q;
  assign err_orphan_o   = err_q;
  assign dbg_state_o    = state_q;
  assign dbg_ptr_o      = ptr_q;

endmodule

// File: tb/tb_avst_packet_arbiter.sv
// Randomized bench for avst_packet_arbiter against a cycle-level arbitration model.
module tb_avst_packet_arbiter;
  import avst_arb_pkg::*;

  localparam int N = 4, CW = 4, DW = 32, EW = 2;
  localparam int BW = 2 + EW + DW;
  localparam int OW = CW + BW;
  localparam int DEPTH = 64;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    sop_i, eop_i, valid_i, ready_o;
  logic [N*EW-1:0] empty_i;
  logic [N*DW-1:0] data_i;
  logic [CW-1:0]   chan_o;
  logic            sop_o, eop_o, valid_o, ready_i, err_o;
  logic [EW-1:0]   empty_o;
  logic [DW-1:0]   data_o;
  arb_state_t      dbg_state;
  logic [1:0]      dbg_ptr;

  avst_packet_arbiter #(.num_inputs(N), .channel_width(CW), .data_width(DW), .empty_width(EW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avst_sop_i     (sop_i),
    .avst_eop_i     (eop_i),
    .avst_empty_i   (empty_i),
    .avst_data_i    (data_i),
    .avst_valid_i   (valid_i),
    .avst_ready_o   (ready_o),
    .avst_channel_o (chan_o),
    .avst_sop_o     (sop_o),
    .avst_eop_o     (eop_o),
    .avst_empty_o   (empty_o),
    .avst_data_o    (data_o),
    .avst_valid_o   (valid_o),
    .avst_ready_i   (ready_i),
    .err_orphan_o   (err_o),
    .dbg_state_o    (dbg_state),
    .dbg_ptr_o      (dbg_ptr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // per-source beat queues: {sop, eop, empty, data}
  logic [BW-1:0] src_buf [N][DEPTH];
  int src_head [N];
  int src_cnt  [N];
  int src_taken[N];

  // reference model state
  bit  m_locked, m_ovalid, m_err;
  int  m_grant, m_ptr;
  logic [OW-1:0] exp_q[$];
  int  ch_log[$];
  int  cyc_log[$];
  int  cyc = 0;
  int  err_seen = 0;
  int  gap_pct = 0;
  int  rdy_pct = 100;

  task automatic push_pkt(input int k, input int len, input bit orphan);
    for (int i = 0; i < len; i++) begin
      logic [BW-1:0] b;
      b[DW-1:0]     = $urandom;
      b[DW +: EW]   = EW'($urandom_range(0, 3));
      b[DW+EW]      = (i == len - 1);
      b[DW+EW+1]    = (i == 0) && !orphan;
      src_buf[k][(src_head[k] + src_cnt[k]) % DEPTH] = b;
      src_cnt[k]++;
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_ovalid = 0; m_err = 0;
    m_grant = 0; m_ptr = 0;
    exp_q.delete();
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    logic [N-1:0]  exp_rdy;
    logic [BW-1:0] b;
    logic [OW-1:0] got_beat, exp_beat;
    bit load, orph;
    int pick, acc;

    check("valid_o", valid_o, m_ovalid);
    check("err_orphan_o", err_o, m_err);
    check("state", dbg_state, m_locked);
    check("ptr", dbg_ptr, m_ptr);
    if (err_o) err_seen++;

    ready_i = ($urandom_range(0, 99) < rdy_pct);
    for (int k = 0; k < N; k++) begin
      valid_i[k] = (src_cnt[k] > 0) && ($urandom_range(0, 99) >= gap_pct);
      b = valid_i[k] ? src_buf[k][src_head[k]] : BW'({$urandom, $urandom});
      data_i[k*DW +: DW]  = b[DW-1:0];
      empty_i[k*EW +: EW] = b[DW +: EW];
      eop_i[k]            = b[DW+EW];
      sop_i[k]            = b[DW+EW+1];
    end
    #1;

    load = !m_ovalid || ready_i;
    exp_rdy = '0; acc = -1; orph = 0; pick = -1;
    if (!m_locked) begin
      for (int off = 0; off < N; off++) begin
        int k;
        k = (m_ptr + off) % N;
        if (pick < 0 && valid_i[k] && sop_i[k]) pick = k;
      end
      if (pick >= 0) begin
        exp_rdy[pick] = load;
        if (load) acc = pick;
      end
      for (int k = 0; k < N; k++)
        if (valid_i[k] && !sop_i[k]) begin
          exp_rdy[k] = 1'b1;
          orph = 1;
        end
    end else begin
      exp_rdy[m_grant] = load;
      if (load && valid_i[m_grant]) acc = m_grant;
    end
    check("ready_o", ready_o, exp_rdy);

    if (valid_o && ready_i) begin
      got_beat = {chan_o, sop_o, eop_o, empty_o, data_o};
      check("beat_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_beat = exp_q.pop_front();
        check("out_beat", got_beat, exp_beat);
      end
      ch_log.push_back(int'(chan_o));
      cyc_log.push_back(cyc);
    end

    if (acc >= 0) begin
      exp_q.push_back({CW'(acc), sop_i[acc], eop_i[acc], empty_i[acc*EW +: EW], data_i[acc*DW +: DW]});
      if (!m_locked) begin
        if (eop_i[acc]) m_ptr = (acc + 1) % N;
        else begin
          m_locked = 1;
          m_grant  = acc;
        end
      end else if (eop_i[acc]) begin
        m_locked = 0;
        m_ptr    = (m_grant + 1) % N;
      end
    end
    for (int k = 0; k < N; k++)
      if (valid_i[k] && exp_rdy[k]) begin
        src_head[k] = (src_head[k] + 1) % DEPTH;
        src_cnt[k]--;
        src_taken[k]++;
      end
    m_ovalid = (acc >= 0) ? 1'b1 : (ready_i ? 1'b0 : m_ovalid);
    m_err    = orph;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    valid_i = '0; sop_i = '0; eop_i = '0; empty_i = '0; data_i = '0; ready_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      src_head[k] = 0; src_cnt[k] = 0; src_taken[k] = 0;
    end
    model_reset();
    ch_log.delete(); cyc_log.delete();
    gap_pct = 0; rdy_pct = 100;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (src_cnt[k] != 0) return 0;
    return 1;
  endfunction

  initial begin
    int pkts, bound, es;

    // reset state
    do_reset();
    check("rst_valid", valid_o, 0);
    check("rst_sop", sop_o, 0);
    check("rst_eop", eop_o, 0);
    check("rst_empty", empty_o, 0);
    check("rst_data", data_o, 0);
    check("rst_chan", chan_o, 0);
    check("rst_ready", ready_o, 0);
    check("rst_err", err_o, 0);
    check("rst_state", dbg_state, 0);
    check("rst_ptr", dbg_ptr, 0);

    // single source, 1000 packets, downstream always ready
    pkts = 0; bound = 0;
    while ((pkts < 1000 || src_cnt[0] > 0 || m_ovalid) && bound < 40000) begin
      if (src_cnt[0] == 0 && pkts < 1000) begin
        push_pkt(0, $urandom_range(5, 30), 0);
        pkts++;
      end
      step();
      bound++;
    end
    check("p1_done", bound < 40000, 1);
    check("p1_drained", exp_q.size(), 0);

    // all sources request at once, 3 beats each
    do_reset();
    for (int k = 0; k < N; k++) push_pkt(k, 3, 0);
    repeat (14) step();
    check("p2_count", ch_log.size(), 12);
    for (int i = 0; i < ch_log.size() && i < 12; i++) begin
      check("p2_chan", ch_log[i], i / 3);
      check("p2_nobubble", cyc_log[i], cyc_log[0] + i);
    end
    check("p2_ptr", dbg_ptr, 0);

    // source 1 requests while source 2 holds the lock
    do_reset();
    push_pkt(2, 6, 0);
    repeat (2) step();
    push_pkt(1, 3, 0);
    repeat (10) step();
    check("p3_count", ch_log.size(), 9);
    for (int i = 0; i < ch_log.size() && i < 9; i++) begin
      check("p3_chan", ch_log[i], (i < 6) ? 2 : 1);
      check("p3_nobubble", cyc_log[i], cyc_log[0] + i);
    end

    // 50% downstream back-pressure on a 20-beat packet
    do_reset();
    rdy_pct = 50;
    push_pkt(0, 20, 0);
    bound = 0;
    while ((src_cnt[0] > 0 || m_ovalid) && bound < 400) begin
      step();
      bound++;
    end
    check("p4_done", bound < 400, 1);
    check("p4_count", ch_log.size(), 20);

    // single orphan on source 3 while idle
    do_reset();
    push_pkt(3, 1, 1);
    es = err_seen;
    repeat (5) step();
    check("p5_pulses", err_seen - es, 1);
    check("p5_no_output", ch_log.size(), 0);
    check("p5_taken", src_taken[3], 1);

    // reset in the middle of a 12-beat packet
    do_reset();
    push_pkt(1, 12, 0);
    bound = 0;
    while (src_taken[1] < 7 && bound < 50) begin
      step();
      bound++;
    end
    check("p6_seven_taken", src_taken[1], 7);
    reset_n = 1'b0;
    #1;
    check("p6_async_valid", valid_o, 0);
    check("p6_async_sop", sop_o, 0);
    check("p6_async_data", data_o, 0);
    check("p6_async_chan", chan_o, 1'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    es = err_seen;
    repeat (8) step();
    check("p6_orphan_pulses", err_seen - es, 5);
    check("p6_discarded", src_taken[1], 12);

    // mixed random traffic with orphans, gaps and back-pressure
    do_reset();
    gap_pct = 20; rdy_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++)
        if (src_cnt[k] == 0 && $urandom_range(0, 99) < 30)
          push_pkt(k, $urandom_range(1, 8), $urandom_range(0, 99) < 10);
      step();
    end
    gap_pct = 0; rdy_pct = 100;
    bound = 0;
    while ((!all_empty() || m_ovalid) && bound < 500) begin
      step();
      bound++;
    end
    check("p7_drain", bound < 500, 1);
    check("p7_exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
